// File: rtl/mul_red_sched.sv
// mul_red_sched: round-robin sharing of one mul_Red_0 multiplier between two requesters,
// with sel_a flush gaps, mode alignment at the multiplier output and tagged result return.
module mul_red_sched #(
    parameter int MR_LAT  = 5,
    parameter int SEL_GAP = 3,
    parameter int DW      = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_w,
    input  logic          req0_mode,
    input  logic [1:0]    req0_sel,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_w,
    input  logic          req1_mode,
    input  logic [1:0]    req1_sel,
    output logic [DW-1:0] mr_A,
    output logic [DW-1:0] mr_w,
    output logic [1:0]    mr_sel_a,
    output logic          mr_mode,
    input  logic [DW-1:0] mr_result,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    output logic          busy
);
    localparam int GW = $clog2(SEL_GAP + 1);

    logic [GW-1:0]   gap_cnt;
    logic            rr;
    logic [MR_LAT:0] pv, pp;
    logic [MR_LAT-1:0] pm;
    logic            grant0, grant1, sel_change, hs;
    logic [1:0]      gsel;

    always_comb begin
        grant1     = req1_valid && (!req0_valid || rr);
        grant0     = req0_valid && !grant1;
        gsel       = grant1 ? req1_sel : req0_sel;
        sel_change = (req0_valid || req1_valid) && gsel != mr_sel_a;
        req0_ready = grant0 && gap_cnt == '0 && !sel_change;
        req1_ready = grant1 && gap_cnt == '0 && !sel_change;
        hs         = req0_ready || req1_ready;
        busy       = |pv || rsp0_valid || rsp1_valid || gap_cnt != '0;
    end

    // Stage 0 rides alongside mr_A; stage MR_LAT lines up with mr_result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mr_A       <= '0;
            mr_w       <= '0;
            mr_sel_a   <= '0;
            mr_mode    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            gap_cnt    <= '0;
            rr         <= 1'b0;
            pv         <= '0;
            pp         <= '0;
            pm         <= '0;
        end else begin
            if (sel_change) begin
                mr_sel_a <= gsel;
                gap_cnt  <= GW'(SEL_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (hs) begin
                mr_A <= grant1 ? req1_a : req0_a;
                mr_w <= grant1 ? req1_w : req0_w;
                rr   <= grant0;
            end
            pv <= {pv[MR_LAT-1:0], hs};
            pp <= {pp[MR_LAT-1:0], grant1};
            pm <= {pm[MR_LAT-2:0], grant1 ? req1_mode : req0_mode};
            // The multiplier applies mode at its output mux, so mode follows the op into the last stage.
            if (pv[MR_LAT-1]) mr_mode <= pm[MR_LAT-1];
            rsp0_valid <= pv[MR_LAT] && !pp[MR_LAT];
            rsp1_valid <= pv[MR_LAT] && pp[MR_LAT];
            if (pv[MR_LAT] && !pp[MR_LAT]) rsp0_data <= mr_result;
            if (pv[MR_LAT] && pp[MR_LAT]) rsp1_data <= mr_result;
        end
    end
endmodule
